// File: rtl/tdm_demux_1to8.sv
// tdm_demux_1to8
// This is the receive end of the 8-slot TDM link. Accepted samples are
// steered into a shadow frame by a slot counter. A completed frame is
// published to dout as one registered word.
module tdm_demux_1to8 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [8*WIDTH-1:0] dout,
  output logic               frame_valid,
  output logic               sync_err,
  output logic               locked,
  output logic [2:0]         slot
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  logic [2:0]           r_slot;
  logic [8*WIDTH-1:0]   r_shadow;
  logic [8*WIDTH-1:0]   r_dout;
  logic                 r_frame_valid;
  logic                 r_sync_err;
  logic                 r_locked;

  logic                 w_realign;
  logic                 w_last_slot;

  // A sync that arrives while a frame is partly assembled restarts the frame at slot 0.
  assign w_realign   = (r_state == ST_LOCKED) && frame_sync && (r_slot != 3'd0);
  assign w_last_slot = (r_slot == 3'd7);

  // Frame lock FSM: slot steering, shadow assembly, publishing, and the pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_HUNT;
      r_slot        <= '0;
      r_shadow      <= '0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      if (din_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (frame_sync) begin
              r_shadow[WIDTH-1:0] <= din;
              r_slot              <= 3'd1;
              r_state             <= ST_LOCKED;
              r_locked            <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (w_realign) begin
              // The partial frame is abandoned. dout keeps the last complete frame.
              r_sync_err          <= 1'b1;
              r_shadow[WIDTH-1:0] <= din;
              r_slot              <= 3'd1;
            end else begin
              for (int unsigned k = 0; k < 8; k++) begin
                if (r_slot == 3'(k)) begin
                  r_shadow[k*WIDTH +: WIDTH] <= din;
                end
              end
              r_slot <= r_slot + 3'd1;
              if (w_last_slot) begin
                r_dout        <= {din, r_shadow[7*WIDTH-1:0]};
                r_frame_valid <= 1'b1;
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_slot   <= '0;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout        = r_dout;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = r_locked;
  assign slot        = r_slot;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// tb_tdm_demux_1to8
// This bench drives the WIDTH=1 demux with table vectors, hand-written
// sequences and random stimulus. Every cycle is compared against a
// frame-level reference model.
module tb_tdm_demux_1to8;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] dout;
  logic       frame_valid;
  logic       sync_err;
  logic       locked;
  logic [2:0] slot;

  int checks   = 0;
  int failures = 0;

  tdm_demux_1to8 #(.WIDTH(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked),
    .slot        (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It tracks the samples gathered since the frame start
  // and whether the receiver has locked.
  bit         m_locked;
  bit         m_part[$];
  logic [7:0] m_dout;
  bit         m_fv;
  bit         m_serr;

  task automatic model_reset();
    m_locked = 0;
    m_part.delete();
    m_dout = 8'h00;
    m_fv = 0;
    m_serr = 0;
  endtask

  task automatic model_step(input bit d, input bit v, input bit s);
    m_fv = 0;
    m_serr = 0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1;
          m_part.delete();
          m_part.push_back(d);
        end
      end else if (s && m_part.size() != 0) begin
        m_serr = 1;
        m_part.delete();
        m_part.push_back(d);
      end else begin
        m_part.push_back(d);
        if (m_part.size() == 8) begin
          for (int k = 0; k < 8; k++) m_dout[k] = m_part[k];
          m_fv = 1;
          m_part.delete();
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("dout", 32'(dout), 32'(m_dout));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("sync_err", 32'(sync_err), 32'(m_serr));
    check("locked", 32'(locked), 32'(m_locked));
    check("slot", 32'(slot), 32'(m_part.size()));
  endtask

  // Inputs are driven 1 time unit after a rising edge. Outputs are sampled 1 time unit after the next edge.
  task automatic cycle(input bit d, input bit v, input bit s);
    din = d;
    din_valid = v;
    frame_sync = s;
    @(posedge clk);
    model_step(d, v, s);
    #1;
    check_model();
  endtask

  task automatic send_frame(input logic [7:0] val, input bit sync_first);
    for (int k = 0; k < 8; k++) cycle(val[k], 1'b1, sync_first && (k == 0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_slot", 32'(slot), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_serr", 32'(sync_err), 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         din;
    bit         valid;
    bit         sync;
    logic [7:0] e_dout;
    bit         e_fv;
    bit         e_serr;
    bit         e_lk;
    logic [2:0] e_slot;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit d, input bit v, input bit s, input logic [7:0] ed,
                     input bit efv, input bit ese, input bit elk, input logic [2:0] esl);
    vec_t r;
    r.din = d; r.valid = v; r.sync = s;
    r.e_dout = ed; r.e_fv = efv; r.e_serr = ese; r.e_lk = elk; r.e_slot = esl;
    tbl.push_back(r);
  endtask

  initial begin
    int fv_cycle[$];
    logic [7:0] v8;

    // Frame 0,1,0,1,0,0,1,1 gives CA.
    add(0,1,1, 8'h00,0,0,1,3'd1);
    add(1,1,0, 8'h00,0,0,1,3'd2);
    add(0,1,0, 8'h00,0,0,1,3'd3);
    add(1,1,0, 8'h00,0,0,1,3'd4);
    add(0,1,0, 8'h00,0,0,1,3'd5);
    add(0,1,0, 8'h00,0,0,1,3'd6);
    add(1,1,0, 8'h00,0,0,1,3'd7);
    add(1,1,0, 8'hCA,1,0,1,3'd0);
    add(0,0,0, 8'hCA,0,0,1,3'd0);
    // A realign at slot 4 drops the partial frame. Seven more samples complete FE.
    add(1,1,1, 8'hCA,0,0,1,3'd1);
    add(0,1,0, 8'hCA,0,0,1,3'd2);
    add(1,1,0, 8'hCA,0,0,1,3'd3);
    add(1,1,0, 8'hCA,0,0,1,3'd4);
    add(0,1,1, 8'hCA,0,1,1,3'd1);
    add(1,1,0, 8'hCA,0,0,1,3'd2);
    add(1,1,0, 8'hCA,0,0,1,3'd3);
    add(1,1,0, 8'hCA,0,0,1,3'd4);
    add(1,1,0, 8'hCA,0,0,1,3'd5);
    add(1,1,0, 8'hCA,0,0,1,3'd6);
    add(1,1,0, 8'hCA,0,0,1,3'd7);
    add(1,1,0, 8'hFE,1,0,1,3'd0);
    add(0,0,0, 8'hFE,0,0,1,3'd0);

    din = 0; din_valid = 0; frame_sync = 0;
    rst_n = 1'b0;
    model_reset();
    #3;
    check("por_dout", 32'(dout), 32'h0);
    check("por_locked", 32'(locked), 32'h0);
    check("por_slot", 32'(slot), 32'h0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      cycle(tbl[i].din, tbl[i].valid, tbl[i].sync);
      check($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
      check($sformatf("tbl%0d_fv", i), 32'(frame_valid), 32'(tbl[i].e_fv));
      check($sformatf("tbl%0d_serr", i), 32'(sync_err), 32'(tbl[i].e_serr));
      check($sformatf("tbl%0d_lk", i), 32'(locked), 32'(tbl[i].e_lk));
      check($sformatf("tbl%0d_slot", i), 32'(slot), 32'(tbl[i].e_slot));
    end

    // Valid is high only every other cycle. The slot holds during the gaps.
    do_reset();
    v8 = 8'hCA;
    for (int k = 0; k < 8; k++) begin
      cycle(v8[k], 1'b1, k == 0);
      cycle(1'b1, 1'b0, 1'b1);
      check("gap_slot", 32'(slot), 32'((k + 1) % 8));
    end
    check("gap_dout", 32'(dout), 32'hCA);

    // Junk samples in HUNT are ignored. A synced frame then gives 5A.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("hunt_locked", 32'(locked), 32'h0);
    send_frame(8'h5A, 1'b1);
    check("hunt_dout", 32'(dout), 32'h5A);
    check("hunt_fv", 32'(frame_valid), 32'h1);
    cycle(1'b0, 1'b0, 1'b0);
    check("hunt_fv_clr", 32'(frame_valid), 32'h0);

    // Frames CA and 35 are sent back-to-back. The second frame has no sync.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      v8 = (c < 8) ? 8'hCA : 8'h35;
      cycle(v8[c % 8], 1'b1, c == 0);
      if (frame_valid) fv_cycle.push_back(c);
    end
    check("b2b_pulses", 32'(fv_cycle.size()), 32'd2);
    if (fv_cycle.size() == 2) check("b2b_spacing", 32'(fv_cycle[1] - fv_cycle[0]), 32'd8);
    check("b2b_dout", 32'(dout), 32'h35);

    // An asynchronous reset arrives at slot 5 with CA on dout.
    send_frame(8'h0F, 1'b0);
    do_reset();
    send_frame(8'hCA, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, k == 0);
    check("mid_slot_pre", 32'(slot), 32'd5);
    do_reset();
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b0);
    check("mid_dout_after", 32'(dout), 32'h0);
    check("mid_locked_after", 32'(locked), 32'h0);

    // Random stimulus with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
